crc_tx_framer: RTL
==================

// Module: crc_tx_framer
// PURPOSE
//  Sequences one external CRC-8 engine (poly 0x07, init 0xFF) on the transmit path.
//  Passes a byte stream through a single output register and appends one CRC byte per frame.
//  Drives the engine's init/calc/data inputs and samples its CRC output.
//  Sits between the TX packet source and the LVDS serializer.
// PARAMETERS
//  MAX_LEN  64                    maximum payload bytes per frame; reaching it forces frame end
//  LEN_W    $clog2(MAX_LEN+1)     width of internal payload byte counter
// PORTS
//  i_clk       in   1  clock
//  i_arst_n    in   1  asynchronous active-low reset
//  i_abort     in   1  synchronous frame abort, highest priority
//  s_valid     in   1  upstream byte valid
//  s_ready     out  1  upstream byte accept
//  s_data      in   8  upstream payload byte
//  s_last      in   1  last payload byte of frame
//  m_valid     out  1  downstream byte valid (registered)
//  m_ready     in   1  downstream accept
//  m_data      out  8  downstream byte (payload or CRC)
//  m_last      out  1  high only with CRC byte
//  o_crc_init  out  1  to engine: reload INIT
//  o_crc_calc  out  1  to engine: fold o_crc_data
//  o_crc_data  out  8  to engine: data byte (= s_data)
//  i_crc       in   8  from engine: current CRC register
//  o_len_err   out  1  one-cycle pulse: MAX_LEN reached without s_last
//  o_busy      out  1  state!=IDLE or m_valid
// BEHAVIOUR
//  Reset: state IDLE, count 0, m_valid/m_last/o_len_err 0, m_data 0x00; s_ready forced 0 while i_arst_n low.
//  FSM states:
//   IDLE  no frame in progress; engine holds INIT.
//   DATA  frame open.
//   CRC   payload complete; CRC byte pending.
//  Handshake:
//   out_free = ~m_valid | m_ready.
//   s_ready = out_free & (state!=CRC) & ~i_abort.
//   accept = s_valid & s_ready.
//  On accept:
//   - m_data<=s_data, m_valid<=1, m_last<=0.
//   - o_crc_calc=1 same cycle (combinational).
//   - count+1.
//  Accept latency: byte on m_* one cycle after accept edge.
//  No accept and m_ready: m_valid<=0.
//  Transitions:
//   - IDLE->DATA: accept & ~s_last & count+1<MAX_LEN.
//   - IDLE/DATA->CRC: accept & (s_last | count+1==MAX_LEN).
//   - On MAX_LEN end without s_last: o_len_err=1 for one cycle; next upstream byte starts a new frame.
//   - CRC->IDLE: when out_free, load m_data<=i_crc, m_valid<=1, m_last<=1.
//     Same cycle: o_crc_init=1, count<=0.
//  CRC byte timing:
//   - i_crc is final one cycle after last accept.
//   - Earliest CRC load is the edge after last accept, giving back-to-back output.
//  Throughput: L payload bytes -> L+1 output beats; s_ready low at least one cycle per frame.
//  o_crc_init and o_crc_calc are never high in the same cycle.
//  m_valid, m_data and m_last hold stable while m_valid & ~m_ready.
//  i_abort (any state):
//   - next state IDLE; m_valid<=0, m_last<=0, count<=0.
//   - o_crc_init=1, o_crc_calc=0, s_ready=0.
//   - Any partial frame is discarded without a CRC byte.
//  Reset mid-frame: all state cleared per reset values; the engine resets to INIT on its own reset.
// TESTING
//  T1: frame {0x00}, last=1, m_ready=1 -> m: 0x00 (last=0), then 0xF3 (last=1); o_crc_init pulses once.
//  T2: frame {0xFF}, last=1 -> m: 0xFF, then 0x00 (last=1); back-to-back frames, no gap beyond 1 s_ready-low cycle.
//  T3: 4-byte frame with m_ready random 50% -> m_* stable while stalled.
//      Output bytes in order, CRC matches software CRC-8(0x07, 0xFF).
//  T4: MAX_LEN=4, 6 bytes with no s_last -> o_len_err pulse at 4th accept, CRC emitted after byte 4.
//      Bytes 5-6 start a new frame.
//  T5: i_abort after 2 of 5 bytes -> m_valid=0 next cycle, no CRC byte, o_crc_init=1.
//      Next frame {0x00} yields CRC 0xF3.
//  T6: i_arst_n low while in CRC state -> all outputs at reset values, s_ready=0.
//      After release, frame {0xFF} yields CRC 0x00.

Source files
------------

// File: rtl/crc_tx_framer.sv
// CRC-8 transmit framer: forwards payload bytes through one output register,
// steers an external CRC-8 engine and appends its result as the frame's last byte.
module crc_tx_framer #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_abort,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       o_crc_init,
  output logic       o_crc_calc,
  output logic [7:0] o_crc_data,
  input  logic [7:0] i_crc,
  output logic       o_len_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] count_inc;
  logic             at_max;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             len_err_q, len_err_d;
  logic             out_free;
  logic             ready;
  logic             accept;
  logic             crc_init;
  logic             crc_calc;

  // Byte count including the byte being accepted this cycle.
  assign count_inc = count_q + LEN_W'(1);
  assign at_max    = (count_inc == LEN_W'(MAX_LEN));

  // Next-state, handshake and engine control; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    len_err_d = 1'b0;
    crc_init  = 1'b0;
    crc_calc  = 1'b0;
    out_free  = ~m_valid_q | m_ready;
    ready     = out_free & (state_q != ST_CRC) & ~i_abort;
    accept    = s_valid & ready;

    if (i_abort) begin
      state_d   = ST_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      count_d   = '0;
      crc_init  = 1'b1;
    end else if (state_q == ST_CRC) begin
      // Engine result is final here; load it as the closing beat and rearm.
      if (out_free) begin
        m_data_d  = i_crc;
        m_valid_d = 1'b1;
        m_last_d  = 1'b1;
        crc_init  = 1'b1;
        count_d   = '0;
        state_d   = ST_IDLE;
      end
    end else if (accept) begin
      m_data_d  = s_data;
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
      crc_calc  = 1'b1;
      count_d   = count_inc;
      len_err_d = ~s_last & at_max;
      if (s_last | at_max) begin
        state_d = ST_CRC;
      end else begin
        state_d = ST_DATA;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register, byte counter and length-error pulse.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      len_err_q <= len_err_d;
    end
  end

  // Reset also blocks the upstream handshake and engine folding.
  assign s_ready    = ready & i_arst_n;
  assign o_crc_calc = crc_calc & i_arst_n;
  assign o_crc_init = crc_init;
  assign o_crc_data = s_data;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign o_len_err  = len_err_q;
  assign o_busy     = (state_q != ST_IDLE) | m_valid_q;

endmodule
